// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback (req0) has priority,
// the multi-cycle unit (req1) gets a forced grant after MAX_WAIT stalled cycles.
//
// state   | meaning
// --------+--------------------------------------------------------------
// NORMAL  | requester 0 has priority, requester 1 served when 0 is idle
// FORCE1  | requester 1 starved MAX_WAIT cycles, it now has priority
module rf_wb_arbiter #(
  parameter int WIDTH    = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  input  logic [4:0]       req0_addr,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [4:0]       req1_addr,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             rf_reg_write,
  output logic [4:0]       rf_waddr,
  output logic [WIDTH-1:0] rf_wdata,
  output logic             rf_grant_id,
  output logic             starve_event
);

  typedef enum logic {
    S_NORMAL = 1'b0,
    S_FORCE1 = 1'b1
  } state_t;

  localparam logic [3:0] WAIT_SAT  = 4'(MAX_WAIT);
  localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

  state_t           state_q, state_d;
  logic [3:0]       wait_cnt_q, wait_cnt_d;
  logic             rf_reg_write_q, rf_reg_write_d;
  logic [4:0]       rf_waddr_q, rf_waddr_d;
  logic [WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic             rf_grant_id_q, rf_grant_id_d;
  logic             starve_event_q, starve_event_d;

  logic grant0, grant1;

  // Grants look only at state and both valids, never at a ready.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == S_FORCE1) begin
      grant1 = req1_valid;
      grant0 = req0_valid & ~req1_valid;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid & ~req0_valid;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;

    if (!req1_valid || grant1) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q != WAIT_SAT) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end

    case (state_q)
      S_NORMAL: begin
        if (req1_valid && !grant1 && wait_cnt_q == WAIT_LAST) begin
          state_d = S_FORCE1;
        end
      end
      S_FORCE1: begin
        if (grant1 || !req1_valid) begin
          state_d = S_NORMAL;
        end
      end
      default: state_d = S_NORMAL;
    endcase
  end

  // Output register: address/data/id hold across idle cycles.
  always_comb begin
    rf_reg_write_d = 1'b0;
    starve_event_d = 1'b0;
    rf_waddr_d     = rf_waddr_q;
    rf_wdata_d     = rf_wdata_q;
    rf_grant_id_d  = rf_grant_id_q;
    if (grant1) begin
      rf_reg_write_d = (req1_addr != 5'd0);
      rf_waddr_d     = req1_addr;
      rf_wdata_d     = req1_data;
      rf_grant_id_d  = 1'b1;
      starve_event_d = (state_q == S_FORCE1) & req0_valid;
    end else if (grant0) begin
      rf_reg_write_d = (req0_addr != 5'd0);
      rf_waddr_d     = req0_addr;
      rf_wdata_d     = req0_data;
      rf_grant_id_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_NORMAL;
      wait_cnt_q     <= 4'd0;
      rf_reg_write_q <= 1'b0;
      rf_waddr_q     <= 5'd0;
      rf_wdata_q     <= '0;
      rf_grant_id_q  <= 1'b0;
      starve_event_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      rf_reg_write_q <= rf_reg_write_d;
      rf_waddr_q     <= rf_waddr_d;
      rf_wdata_q     <= rf_wdata_d;
      rf_grant_id_q  <= rf_grant_id_d;
      starve_event_q <= starve_event_d;
    end
  end

  assign rf_reg_write = rf_reg_write_q;
  assign rf_waddr     = rf_waddr_q;
  assign rf_wdata     = rf_wdata_q;
  assign rf_grant_id  = rf_grant_id_q;
  assign starve_event = starve_event_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios plus randomized traffic, all
// checked against a stall-count reference model of the arbitration rules.
module tb_rf_wb_arbiter;
  localparam int WIDTH    = 32;
  localparam int MAX_WAIT = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             req0_valid, req1_valid;
  logic [4:0]       req0_addr, req1_addr;
  logic [WIDTH-1:0] req0_data, req1_data;
  logic             req0_ready, req1_ready;
  logic             rf_reg_write, rf_grant_id, starve_event;
  logic [4:0]       rf_waddr;
  logic [WIDTH-1:0] rf_wdata;

  int total = 0;
  int bad   = 0;

  // Reference model: req1 gets priority once it has been refused MAX_WAIT
  // cycles in a row; the count restarts whenever req1 is idle or served.
  int               m_stall;
  logic             m_g0, m_g1;
  logic             e_write, e_id, e_starve;
  logic [4:0]       e_addr;
  logic [WIDTH-1:0] e_data;

  rf_wb_arbiter #(.WIDTH(WIDTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
    .req1_ready(req1_ready),
    .rf_reg_write(rf_reg_write), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_grant_id(rf_grant_id), .starve_event(starve_event)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_stall  = 0;
    m_g0     = 1'b0;
    m_g1     = 1'b0;
    e_write  = 1'b0;
    e_id     = 1'b0;
    e_starve = 1'b0;
    e_addr   = '0;
    e_data   = '0;
  endtask

  task automatic chk_rf(input string tag);
    chk({tag, ".rf_reg_write"}, 64'(rf_reg_write), 64'(e_write));
    chk({tag, ".rf_waddr"},     64'(rf_waddr),     64'(e_addr));
    chk({tag, ".rf_wdata"},     64'(rf_wdata),     64'(e_data));
    chk({tag, ".rf_grant_id"},  64'(rf_grant_id),  64'(e_id));
    chk({tag, ".starve_event"}, 64'(starve_event), 64'(e_starve));
  endtask

  // Called at a negedge: drive, check readies, clock once, check outputs.
  task automatic cycle(input string tag,
                       input logic v0, input logic [4:0] a0, input logic [WIDTH-1:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [WIDTH-1:0] d1);
    logic prio1;
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    #1;
    prio1 = (m_stall >= MAX_WAIT);
    m_g1  = v1 && (prio1 || !v0);
    m_g0  = v0 && !m_g1;
    chk({tag, ".req0_ready"}, 64'(req0_ready), 64'(m_g0));
    chk({tag, ".req1_ready"}, 64'(req1_ready), 64'(m_g1));
    @(posedge clk);
    #1;
    if (m_g1) begin
      e_write = (a1 != 5'd0); e_addr = a1; e_data = d1; e_id = 1'b1;
      e_starve = prio1 && v0;
    end else if (m_g0) begin
      e_write = (a0 != 5'd0); e_addr = a0; e_data = d0; e_id = 1'b0;
      e_starve = 1'b0;
    end else begin
      e_write = 1'b0; e_starve = 1'b0;
    end
    m_stall = (!v1 || m_g1) ? 0 : m_stall + 1;
    chk_rf(tag);
    @(negedge clk);
  endtask

  logic             p0v, p1v;
  logic [4:0]       p0a, p1a;
  logic [WIDTH-1:0] p0d, p1d;
  int               r1_grants;

  initial begin
    model_reset();
    reset_n = 1'b0;
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'hA5A5_0003;
    req1_valid = 1'b0; req1_addr = 5'd0; req1_data = '0;
    @(negedge clk);
    @(negedge clk);
    chk_rf("reset");
    reset_n = 1'b1;

    // First request after release
    cycle("t1", 1'b1, 5'd3, 32'hA5A5_0003, 1'b0, 5'd0, 32'h0);
    chk("t1.write_exp", 64'({rf_reg_write, rf_waddr, rf_grant_id}), 64'({1'b1, 5'd3, 1'b0}));

    cycle("t2", 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    chk("t2.wdata_exp", 64'(rf_wdata), 64'(32'hDEAD_BEEF));

    // Continuous contention: r1 forced every 5th cycle
    r1_grants = 0;
    for (int i = 0; i < 10; i++) begin
      cycle("t3", 1'b1, 5'd9, 32'(100 + i), 1'b1, 5'd10, 32'(200 + i));
      if (rf_grant_id) r1_grants++;
      chk("t3.starve_on_r1", 64'(starve_event), 64'(rf_grant_id));
    end
    chk("t3.r1_grant_count", 64'(r1_grants), 64'd2);

    cycle("t4", 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'h0);
    chk("t4.x0_no_write", 64'({rf_reg_write, rf_wdata}), 64'({1'b0, 32'h1234}));

    cycle("t5a", 1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22);
    chk("t5a.first", 64'(rf_wdata), 64'(32'h11));
    cycle("t5b", 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h22);
    chk("t5b.second", 64'(rf_wdata), 64'(32'h22));

    // Reset while r1 has stalled 3 cycles
    cycle("t6i", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 3; i++)
      cycle("t6s", 1'b1, 5'd12, 32'(300 + i), 1'b1, 5'd13, 32'h77);
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("t6.write_drop", 64'(rf_reg_write), 64'd0);
    @(negedge clk);
    chk_rf("t6.in_reset");
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle("t6r", 1'b1, 5'd12, 32'(400 + i), 1'b1, 5'd13, 32'h77);
      chk("t6r.grant_id", 64'(rf_grant_id), 64'(i == 4));
    end

    // Randomized traffic; requesters hold a request until it is accepted
    p0v = 1'b0; p1v = 1'b0;
    p0a = '0; p1a = '0; p0d = '0; p1d = '0;
    for (int i = 0; i < 400; i++) begin
      if (!p0v) begin
        p0v = ($urandom_range(0, 99) < 75);
        p0a = 5'($urandom_range(0, 31));
        p0d = $urandom;
      end
      if (!p1v) begin
        p1v = ($urandom_range(0, 99) < 60);
        p1a = 5'($urandom_range(0, 31));
        p1d = $urandom;
      end
      cycle("rand", p0v, p0a, p0d, p1v, p1a, p1d);
      if (m_g0) p0v = 1'b0;
      if (m_g1) p1v = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port (reg_write/waddr/wdata) between two writeback sources.
- Requester 0 is the in-order pipeline writeback (ALU/load); requester 1 is a multi-cycle unit (mul/div).
- Fixed priority to requester 0, with a starvation guard that forces a requester-1 grant after MAX_WAIT stalled cycles.
- Output is registered, so it drives the register file's write port directly.

Parameters:
- WIDTH, 32, data width of the write port.
- MAX_WAIT, 4, consecutive stalled cycles of requester 1 before a forced grant; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  pipeline writeback request.
- req0_addr  input  5  destination register.
- req0_data  input  WIDTH  write data.
- req0_ready  output  1  grant to requester 0 this cycle (combinational).
- req1_valid  input  1  multi-cycle unit writeback request.
- req1_addr  input  5  destination register.
- req1_data  input  WIDTH  write data.
- req1_ready  output  1  grant to requester 1 this cycle (combinational).
- rf_reg_write  output  1  register-file write enable.
- rf_waddr  output  5  register-file write address.
- rf_wdata  output  WIDTH  register-file write data.
- rf_grant_id  output  1  source of the current rf_* write (0/1).
- starve_event  output  1  one-cycle pulse when a forced grant occurs.

Behaviour:
- Reset (asynchronous, reset_n=0): state=NORMAL, wait_cnt=0, and all registered outputs are 0 (rf_reg_write, rf_waddr, rf_wdata, rf_grant_id, starve_event).
- Reset mid-operation: pending requests are dropped and no write is issued. Requesters keep their valid asserted and re-request after reset.
- Handshake: a transfer happens on a cycle where valid&ready=1. Each ready depends only on the state and both valid inputs, never on its own ready. At most one ready is high per cycle. ready is never asserted without its valid.
- State NORMAL:
  - req0_valid=1 grants requester 0.
  - Otherwise, req1_valid=1 grants requester 1.
- State FORCE1:
  - req1_valid=1 grants requester 1.
  - Otherwise, req0_valid=1 grants requester 0.
- wait_cnt (4 bits):
  - Cleared when req1_valid=0 or requester 1 is granted.
  - Incremented when req1_valid=1 and requester 1 is not granted.
  - Saturates at MAX_WAIT.
- Transitions:
  - NORMAL->FORCE1 when req1_valid=1, requester 1 is not granted, and wait_cnt==MAX_WAIT-1.
  - FORCE1->NORMAL on a requester-1 grant, or when req1_valid=0.
  - No other transitions.
- Write latency is 1 cycle. The cycle after a grant:
  - rf_reg_write=(granted addr!=0).
  - rf_waddr and rf_wdata take the granted addr/data.
  - rf_grant_id takes the granted requester.
  - starve_event=1 if that grant was made in FORCE1 while req0_valid=1.
- Writes to x0: the request is accepted (ready=1) but rf_reg_write stays 0. rf_waddr/rf_wdata still update.
- Idle cycles (no grant): the next cycle has rf_reg_write=0 and starve_event=0. rf_waddr, rf_wdata and rf_grant_id hold their values.
- Back-to-back grants: a write is issued every cycle; there is no bubble.
- Same destination register in the same cycle: only the granted request writes. The loser writes later in grant order, so the later-granted data wins in the register file.
- No buffering: the arbiter holds no request data beyond the output register. Requesters must hold addr/data stable while valid=1 and ready=0.

Test Plan:
1. Reset with req0_valid=1 held → all rf_* outputs are 0. First cycle after release: req0_ready=1. Next cycle: rf_reg_write=1 with req0's addr/data, rf_grant_id=0.
2. Only req1_valid=1, addr=5, data=0xDEADBEEF → req1_ready=1 the same cycle. Next cycle: rf_reg_write=1, rf_waddr=5, rf_wdata=0xDEADBEEF, rf_grant_id=1.
3. Both valid continuously, MAX_WAIT=4 → requester 0 is granted for 4 cycles, then requester 1 on the 5th with starve_event=1 the following cycle. Requester 0 resumes next; the pattern repeats every 5 cycles.
4. req0 addr=0, data=0x1234 → req0_ready=1. The next cycle has rf_reg_write=0, rf_waddr=0, rf_wdata=0x1234.
5. Both requests target addr=7 (d0=0x11, d1=0x22) in the same cycle → writes to 7 in the order 0x11 then 0x22 on consecutive cycles, given req0 then drops.
6. reset_n asserted mid-starvation (wait_cnt=3) → rf_reg_write=0 immediately. After release, state=NORMAL, wait_cnt=0, and requester 1 again needs 4 stalled cycles before a forced grant.
